a2d_scan_intf: RTL and testbench



---
 rtl/a2d_scan_pkg.sv | 20 ++
 rtl/spi_xfer16.sv | 107 ++++++++++
 rtl/a2d_scan_intf.sv | 155 +++++++++++++++
 tb/tb_a2d_scan_intf.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_scan_pkg.sv
// rtl/a2d_scan_pkg.sv - shared types, widths and command-word builder for the A2D scanner
package a2d_scan_pkg;

    localparam int ADC_RES_W  = 12;
    localparam int SPI_WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        GAP,
        READ,
        UPD
    } state_t;

    // ADC128S control word: channel address sits in bits [13:11]
    function automatic logic [SPI_WORD_W-1:0] build_cmd(input logic [2:0] addr);
        return {2'b00, addr, 11'h000};
    endfunction

endpackage

// File: rtl/spi_xfer16.sv
// rtl/spi_xfer16.sv - 16-bit SPI monarch, CPOL=1 CPHA=1, MSB first, SS low for 17 SCLK periods
module spi_xfer16 #(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] resp,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int HALF = SCLK_DIV / 2;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [2:0] {
        X_IDLE,
        X_LEAD,
        X_LOW,
        X_HIGH,
        X_TRAIL
    } xstate_t;

    xstate_t     xs;
    logic [HW-1:0] hcnt;
    logic [4:0]  bitcnt;
    logic [15:0] tx_sr;
    logic [15:0] rx_sr;
    logic        half_end;

    assign half_end = (hcnt == HW'(HALF - 1));

    // Lead-in and trail phases are each half an SCLK period, giving 17 periods with SS low
    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (!rst_n) begin
            xs     <= X_IDLE;
            SS_n   <= 1'b1;
            SCLK   <= 1'b1;
            MOSI   <= 1'b0;
            hcnt   <= '0;
            bitcnt <= '0;
            tx_sr  <= '0;
            rx_sr  <= '0;
            resp   <= '0;
            done   <= 1'b0;
        end else begin
            if (xs != X_IDLE) begin
                hcnt <= half_end ? '0 : hcnt + 1'b1;
            end
            case (xs)
                X_IDLE: begin
                    if (start) begin
                        SS_n   <= 1'b0;
                        tx_sr  <= cmd;
                        bitcnt <= '0;
                        hcnt   <= '0;
                        xs     <= X_LEAD;
                    end
                end
                X_LEAD: begin
                    if (half_end) begin
                        SCLK  <= 1'b0;
                        MOSI  <= tx_sr[15];
                        tx_sr <= {tx_sr[14:0], 1'b0};
                        xs    <= X_LOW;
                    end
                end
                X_LOW: begin
                    if (half_end) begin
                        SCLK   <= 1'b1;
                        rx_sr  <= {rx_sr[14:0], MISO};
                        bitcnt <= bitcnt + 1'b1;
                        xs     <= X_HIGH;
                    end
                end
                X_HIGH: begin
                    if (half_end) begin
                        if (bitcnt == 5'd16) begin
                            xs <= X_TRAIL;
                        end else begin
                            SCLK  <= 1'b0;
                            MOSI  <= tx_sr[15];
                            tx_sr <= {tx_sr[14:0], 1'b0};
                            xs    <= X_LOW;
                        end
                    end
                end
                X_TRAIL: begin
                    if (half_end) begin
                        SS_n <= 1'b1;
                        MOSI <= 1'b0;
                        resp <= rx_sr;
                        done <= 1'b1;
                        xs   <= X_IDLE;
                    end
                end
                default: xs <= X_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/a2d_scan_intf.sv
// rtl/a2d_scan_intf.sv - round-robin ADC128S channel scanner; A2D_SCAN_AVG_EN adds a per-channel IIR filter
module a2d_scan_intf
    import a2d_scan_pkg::*;
#(
    parameter int                  NUM_CH      = 4,
    parameter logic [NUM_CH*3-1:0] CH_MAP      = {3'd4, 3'd3, 3'd1, 3'd0},
    parameter int                  SCLK_DIV    = 32,
    parameter int                  CONV_PERIOD = 1024
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          en,
    input  logic                                          MISO,
    output logic                                          a2d_SS_n,
    output logic                                          SCLK,
    output logic                                          MOSI,
    output logic [NUM_CH*ADC_RES_W-1:0]                   rdata,
    output logic                                          cnv_cmplt,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cnv_ch
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMR_W = (CONV_PERIOD > 1) ? $clog2(CONV_PERIOD) : 1;
    localparam int GAP_W = $clog2(SCLK_DIV);

    state_t                  state;
    logic [TMR_W-1:0]        timer;
    logic                    tick;
    logic                    pending;
    logic [CH_W-1:0]         idx;
    logic [GAP_W-1:0]        gap_cnt;
    logic [2:0]              cur_addr;
    logic                    spi_start;
    logic                    spi_done;
    logic [SPI_WORD_W-1:0]   spi_resp;
    logic [ADC_RES_W-1:0]    sample;
    logic                    unused_resp_hi;

    assign tick           = en && (timer == TMR_W'(CONV_PERIOD - 1));
    assign sample         = spi_resp[ADC_RES_W-1:0];
    assign unused_resp_hi = ^spi_resp[SPI_WORD_W-1:ADC_RES_W];

    // Start is combinational so the SPI engine launches on the same edge the FSM advances;
    // the GAP launch is one count early to keep SS high for exactly SCLK_DIV cycles.
    assign spi_start = ((state == IDLE) && pending && en) ||
                       ((state == GAP) && (gap_cnt == GAP_W'(SCLK_DIV - 2)));

    always_comb begin
        cur_addr = CH_MAP[2:0];
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == CH_W'(i)) cur_addr = CH_MAP[3*i +: 3];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

`ifdef A2D_SCAN_AVG_EN
    logic [NUM_CH-1:0] loaded;

    function automatic logic [ADC_RES_W-1:0] iir(input logic [ADC_RES_W-1:0] old,
                                                 input logic [ADC_RES_W-1:0] smp);
        logic [ADC_RES_W+1:0] acc;
        acc = {2'b00, old} + {1'b0, old, 1'b0} + {2'b00, smp};
        return acc[ADC_RES_W+1:2];
    endfunction
`endif

    always_ff @(posedge clk) begin
        cnv_cmplt <= 1'b0;
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= 1'b0;
            idx       <= '0;
            gap_cnt   <= '0;
            rdata     <= '0;
            cnv_ch    <= '0;
            cnv_cmplt <= 1'b0;
`ifdef A2D_SCAN_AVG_EN
            loaded    <= '0;
`endif
        end else begin
            // A fresh expiry outranks the launch clear so back-to-back requests are not lost
            if (!en) begin
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end else if (state == IDLE) begin
                pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pending && en) state <= CMD;
                end
                CMD: begin
                    if (spi_done) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GAP_W'(SCLK_DIV - 2)) state <= READ;
                end
                READ: begin
                    if (spi_done) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (idx == CH_W'(i)) begin
`ifdef A2D_SCAN_AVG_EN
                                rdata[ADC_RES_W*i +: ADC_RES_W] <= loaded[i] ?
                                    iir(rdata[ADC_RES_W*i +: ADC_RES_W], sample) : sample;
                                loaded[i] <= 1'b1;
`else
                                rdata[ADC_RES_W*i +: ADC_RES_W] <= sample;
`endif
                            end
                        end
                        cnv_cmplt <= 1'b1;
                        cnv_ch    <= idx;
                        state     <= UPD;
                    end
                end
                UPD: begin
                    idx   <= (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    spi_xfer16 #(
        .SCLK_DIV(SCLK_DIV)
    ) u_spi (
        .clk  (clk),
        .rst_n(rst_n),
        .start(spi_start),
        .cmd  (build_cmd(cur_addr)),
        .done (spi_done),
        .resp (spi_resp),
        .SS_n (a2d_SS_n),
        .SCLK (SCLK),
        .MOSI (MOSI),
        .MISO (MISO)
    );

endmodule

// File: tb/tb_a2d_scan_intf.sv
// tb/tb_a2d_scan_intf.sv - self-checking bench for a2d_scan_intf with an ADC128S-style responder
module tb_a2d_scan_intf;

    localparam int NUM_CH      = 4;
    localparam int SCLK_DIV    = 32;
    localparam int CONV_PERIOD = 10;
    localparam int XFER_CYC    = 17 * SCLK_DIV;
    localparam int CONV_LAT    = 2 * XFER_CYC + SCLK_DIV + 2;
    localparam int FIRST_LAT   = CONV_PERIOD + CONV_LAT;
    localparam int B2B_GAP     = CONV_LAT + 1;
    localparam int TIMEOUT     = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        MISO = 1'b0;
    logic        a2d_SS_n;
    logic        SCLK;
    logic        MOSI;
    logic [47:0] rdata;
    logic        cnv_cmplt;
    logic [1:0]  cnv_ch;

    a2d_scan_intf #(
        .NUM_CH     (NUM_CH),
        .SCLK_DIV   (SCLK_DIV),
        .CONV_PERIOD(CONV_PERIOD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .MISO     (MISO),
        .a2d_SS_n (a2d_SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .rdata    (rdata),
        .cnv_cmplt(cnv_cmplt),
        .cnv_ch   (cnv_ch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ADC responder: returns the conversion of the address received in the previous frame
    logic [11:0] adc_val [8];
    logic [3:0]  hi_nib = 4'h0;
    logic [2:0]  prev_addr = 3'd0;
    logic [15:0] tx_word = 16'h0;
    logic [15:0] rx_word = 16'h0;
    logic [15:0] last_cmd = 16'h0;
    int          bit_i = 15;
    int          rises = 0;
    int          last_rises = 0;
    int          ss_cnt = 0;
    int          last_ss_len = 0;
    int          ss_falls = 0;
    int          ss_rises = 0;

    always @(negedge a2d_SS_n) begin
        tx_word = {hi_nib, adc_val[prev_addr]};
        bit_i   = 15;
        rises   = 0;
        rx_word = 16'h0;
        ss_cnt  = 0;
        ss_falls++;
    end

    always @(negedge SCLK) begin
        if (a2d_SS_n === 1'b0) begin
            MISO = tx_word[4'(bit_i)];
            if (bit_i > 0) bit_i--;
        end
    end

    always @(posedge SCLK) begin
        if (a2d_SS_n === 1'b0) begin
            rx_word = {rx_word[14:0], MOSI};
            rises++;
        end
    end

    always @(posedge a2d_SS_n) begin
        last_cmd    = rx_word;
        last_rises  = rises;
        last_ss_len = ss_cnt;
        if (rises == 16) prev_addr = rx_word[13:11];
        ss_rises++;
    end

    always @(negedge clk) begin
        if (a2d_SS_n === 1'b0) ss_cnt++;
    end

    // Reference model state
    int          ch_addr [4] = '{0, 1, 3, 4};
    logic [11:0] exp_rdata [4];
    bit          first [4];
    int          exp_ch = 0;

    typedef struct {
        int          ch;
        logic [15:0] cmd;
        logic [11:0] val;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cmplt(output int cyc);
        cyc = 0;
        while (cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
            if (cnv_cmplt === 1'b1) break;
        end
        if (cnv_cmplt !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL cnv_cmplt_timeout actual=none required=strobe within %0d cycles", TIMEOUT);
        end
    endtask

    task automatic wait_ss(input bit rise);
        int c0;
        int n;
        c0 = rise ? ss_rises : ss_falls;
        n = 0;
        while (n < TIMEOUT && (rise ? ss_rises : ss_falls) == c0) begin
            @(negedge clk);
            n++;
        end
        if ((rise ? ss_rises : ss_falls) == c0) begin
            checks++;
            failures++;
            $display("FAIL ss_edge_timeout actual=none required=%s within %0d cycles",
                     rise ? "rise" : "fall", TIMEOUT);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            exp_rdata[i] = 12'h0;
            first[i]     = 1'b1;
        end
        exp_ch = 0;
    endtask

    task automatic model_write(input int ch, input logic [11:0] v);
`ifdef A2D_SCAN_AVG_EN
        if (first[ch]) exp_rdata[ch] = v;
        else exp_rdata[ch] = 12'((3 * int'(exp_rdata[ch]) + int'(v)) / 4);
`else
        exp_rdata[ch] = v;
`endif
        first[ch] = 1'b0;
    endtask

    task automatic check_conv();
        int addr;
        addr = ch_addr[exp_ch];
        model_write(exp_ch, adc_val[addr]);
        check("cnv_ch", 64'(cnv_ch), 64'(exp_ch));
        check("cmd_word", 64'(last_cmd), 64'(addr * 2048));
        check("rdata_all", 64'(rdata), 64'({exp_rdata[3], exp_rdata[2], exp_rdata[1], exp_rdata[0]}));
        exp_ch = (exp_ch + 1) % 4;
        @(negedge clk);
        check("cnv_cmplt_one_cycle", 64'(cnv_cmplt), 64'(0));
    endtask

    task automatic randomize_adc();
        for (int a = 0; a < 8; a++) adc_val[a] = 12'($urandom);
        hi_nib = 4'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ss_n"}, 64'(a2d_SS_n), 64'(1));
        check({tag, "_sclk"}, 64'(SCLK), 64'(1));
        check({tag, "_mosi"}, 64'(MOSI), 64'(0));
        check({tag, "_rdata"}, 64'(rdata), 64'(0));
        check({tag, "_cnv_cmplt"}, 64'(cnv_cmplt), 64'(0));
        check({tag, "_cnv_ch"}, 64'(cnv_ch), 64'(0));
    endtask

    initial begin
        int cyc;
        int f0;
        int strobes;
        int guard;

        vecs[0] = '{0, 16'h0000, 12'hA00};
        vecs[1] = '{1, 16'h0800, 12'hA01};
        vecs[2] = '{2, 16'h1800, 12'hA03};
        vecs[3] = '{3, 16'h2000, 12'hA04};
        vecs[4] = '{0, 16'h0000, 12'hA00};
        for (int a = 0; a < 8; a++) adc_val[a] = 12'hA00 | 12'(a);
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Disabled: nothing may move for 5000 cycles
        f0 = ss_falls;
        strobes = 0;
        repeat (5000) begin
            @(negedge clk);
            if (cnv_cmplt === 1'b1) strobes++;
        end
        check("idle_ss_falls", 64'(ss_falls - f0), 64'(0));
        check("idle_strobes", 64'(strobes), 64'(0));
        check("idle_ss_n", 64'(a2d_SS_n), 64'(1));
        check("idle_sclk", 64'(SCLK), 64'(1));
        check("idle_rdata", 64'(rdata), 64'(0));

        // Fixed-response scan; CONV_PERIOD is shorter than a conversion so they run back-to-back
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_cmplt(cyc);
            if (i == 0) begin
                check("first_latency", 64'(cyc), 64'(FIRST_LAT));
                check("ss_low_cycles", 64'(last_ss_len), 64'(XFER_CYC));
                check("sclk_rises", 64'(last_rises), 64'(16));
            end else begin
                check("b2b_interval", 64'(cyc + 1), 64'(B2B_GAP));
            end
            check("vec_cnv_ch", 64'(cnv_ch), 64'(vecs[i].ch));
            check("vec_cmd", 64'(last_cmd), 64'(vecs[i].cmd));
            check("vec_rdata", 64'(rdata[12*vecs[i].ch +: 12]), 64'(vecs[i].val));
            model_write(vecs[i].ch, vecs[i].val);
            exp_ch = (vecs[i].ch + 1) % 4;
            @(negedge clk);
            check("vec_cnv_cmplt_one_cycle", 64'(cnv_cmplt), 64'(0));
        end

        // Random ADC data, with en occasionally dropped mid-conversion
        for (int k = 0; k < 8; k++) begin
            randomize_adc();
            if ($urandom_range(0, 2) == 0) begin
                wait_ss(1'b0);
                repeat ($urandom_range(1, 1000)) @(negedge clk);
                en = 1'b0;
                wait_cmplt(cyc);
                check_conv();
                f0 = ss_falls;
                repeat (2000) @(negedge clk);
                check("disabled_no_scan", 64'(ss_falls - f0), 64'(0));
                en = 1'b1;
                wait_cmplt(cyc);
                check("reenable_latency", 64'(cyc), 64'(FIRST_LAT));
                check_conv();
            end else begin
                wait_cmplt(cyc);
                check("rand_b2b_interval", 64'(cyc + 1), 64'(B2B_GAP));
                check_conv();
            end
        end

        // Reset during the READ frame of channel 2
        guard = 0;
        while (exp_ch != 2 && guard < 4) begin
            wait_cmplt(cyc);
            check_conv();
            guard++;
        end
        wait_ss(1'b0);
        wait_ss(1'b1);
        wait_ss(1'b0);
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        model_reset();
        rst_n = 1'b1;
        wait_cmplt(cyc);
        check("restart_latency", 64'(cyc), 64'(FIRST_LAT));
        check_conv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
